seg7_scan_ctrl: RTL and testbench

Time-multiplexing controller for a common-anode multi-digit seven-segment display. All digits share one seven-segment decoder. The block holds a double-buffered BCD display word and steps through the digits one slot at a time, inserting dead time between slots. It also applies leading-zero blanking and decimal points, and commits new display data only at frame boundaries. It sits between the traffic-timer countdown logic and the board's segment/digit pins.

---
 rtl/seg7_scan_ctrl_pkg.sv | 36 +++
 rtl/seg7_scan_ctrl_decode.sv | 30 +++
 rtl/seg7_scan_ctrl.sv | 176 +++++++++++++++++
 tb/tb_seg7_scan_ctrl.sv | 340 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/seg7_scan_ctrl_pkg.sv
// Shared definitions for the seven-segment scan controller: segment
// bit order, active-low digit patterns, the dp bit index and the scan states.
package seg7_scan_ctrl_pkg;

  // Segment bus order is {a,b,c,d,e,f,g,dp}, active-low (0 = segment lit).
  localparam int SEG_W  = 8;
  localparam int DP_BIT = 0;

  localparam logic [SEG_W-1:0] SEG_BLANK = 8'hFF;
  localparam logic [SEG_W-1:0] SEG_0     = 8'h03;
  localparam logic [SEG_W-1:0] SEG_1     = 8'h9F;
  localparam logic [SEG_W-1:0] SEG_2     = 8'h25;
  localparam logic [SEG_W-1:0] SEG_3     = 8'h0D;
  localparam logic [SEG_W-1:0] SEG_4     = 8'h99;
  localparam logic [SEG_W-1:0] SEG_5     = 8'h49;
  localparam logic [SEG_W-1:0] SEG_6     = 8'h41;
  localparam logic [SEG_W-1:0] SEG_7     = 8'h1B;  // 7 drawn with the f segment
  localparam logic [SEG_W-1:0] SEG_8     = 8'h01;
  localparam logic [SEG_W-1:0] SEG_9     = 8'h09;

  // Scan slot phase: dead time first, then the digit is driven.
  typedef enum logic {
    ST_BLANK = 1'b0,
    ST_DRIVE = 1'b1
  } scan_state_t;

  // Light the decimal point on top of an already chosen segment pattern.
  function automatic logic [SEG_W-1:0] seg_with_dp(input logic [SEG_W-1:0] seg,
                                                   input logic dp);
    logic [SEG_W-1:0] r;
    r = seg;
    if (dp) r[DP_BIT] = 1'b0;
    return r;
  endfunction

endpackage

// File: rtl/seg7_scan_ctrl_decode.sv
// Combinational BCD-to-seven-segment decoder (shared DECODE7 block).
// Produces the active-low pattern with dp dark, plus a flag for digits 0..9.
module seg7_scan_ctrl_decode
  import seg7_scan_ctrl_pkg::*;
(
  input  logic [3:0]       bcd,
  output logic [SEG_W-1:0] seg,
  output logic             valid
);

  // Table lookup; codes above 9 decode dark and are flagged invalid.
  always_comb begin
    seg   = SEG_BLANK;
    valid = 1'b1;
    case (bcd)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: valid = 1'b0;
    endcase
  end

endmodule

// File: rtl/seg7_scan_ctrl.sv
// Time-multiplexed scan controller for a common-anode seven-segment display.
// Steps through the digits one slot at a time with dead time at the start of
// each slot, applies leading-zero blanking and decimal points, and swaps in
// new display data only at frame boundaries.
module seg7_scan_ctrl
  import seg7_scan_ctrl_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int DIV        = 50000,
  parameter int BLANK_CYC  = 16
) (
  input  logic                    CLK,
  input  logic                    RST_N,
  input  logic                    LOAD,
  input  logic [4*NUM_DIGITS-1:0] DATA_IN,
  input  logic [NUM_DIGITS-1:0]   DP_IN,
  input  logic                    LZB_EN,
  output logic                    ACK,
  output logic [SEG_W-1:0]        SEG_OUT,
  output logic [NUM_DIGITS-1:0]   DIG_SEL,
  output logic                    FRAME_TICK
);

  localparam int CNT_W = $clog2(DIV);
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);
  // With no dead time the slot opens directly in DRIVE.
  localparam scan_state_t STATE_RST = (BLANK_CYC == 0) ? ST_DRIVE : ST_BLANK;

  logic [CNT_W-1:0]        cnt_reg, cnt_next;
  logic [IDX_W-1:0]        idx_reg, idx_next;
  scan_state_t             state_reg, state_next;

  logic [4*NUM_DIGITS-1:0] shadow_data_reg;
  logic [NUM_DIGITS-1:0]   shadow_dp_reg;
  logic                    shadow_lzb_reg;
  logic                    pending_reg;

  logic [4*NUM_DIGITS-1:0] active_data_reg;
  logic [NUM_DIGITS-1:0]   active_dp_reg;
  logic                    active_lzb_reg;
  logic                    active_valid_reg;

  logic [SEG_W-1:0]        seg_reg, seg_next;
  logic [NUM_DIGITS-1:0]   dig_reg, dig_next;
  logic                    ack_reg;
  logic                    tick_reg;

  logic                    frame_end;
  logic [3:0]              act_nib [NUM_DIGITS];
  logic [3:0]              cur_nib;
  logic [NUM_DIGITS-1:0]   lzb_mask;
  logic [SEG_W-1:0]        dec_seg;
  logic                    dec_valid;

  // Marks leading zero digits, scanning from the leftmost digit down.
  // Digit 0 is never marked; a non-BCD nibble counts as significant.
  function automatic logic [NUM_DIGITS-1:0] lz_mask(input logic [4*NUM_DIGITS-1:0] d);
    logic                  seen;
    logic [NUM_DIGITS-1:0] m;
    seen = 1'b0;
    m    = '0;
    for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
      if (d[4*i +: 4] != 4'd0) seen = 1'b1;
      m[i] = ~seen;
    end
    return m;
  endfunction

  assign frame_end = (idx_reg == IDX_LAST) && (cnt_reg == CNT_LAST);

  // Split the active display word into per-digit nibbles.
  for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_nib
    assign act_nib[gi] = active_data_reg[4*gi +: 4];
  end

  assign cur_nib  = act_nib[idx_reg];
  assign lzb_mask = active_lzb_reg ? lz_mask(active_data_reg) : '0;

  seg7_scan_ctrl_decode u_decode7 (
    .bcd   (cur_nib),
    .seg   (dec_seg),
    .valid (dec_valid)
  );

  // Scan position and slot phase register.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      cnt_reg   <= '0;
      idx_reg   <= '0;
      state_reg <= STATE_RST;
    end else begin
      cnt_reg   <= cnt_next;
      idx_reg   <= idx_next;
      state_reg <= state_next;
    end
  end

  // Next scan position; the phase is derived from where the slot counter lands.
  always_comb begin
    cnt_next = cnt_reg + CNT_W'(1);
    idx_next = idx_reg;
    if (cnt_reg == CNT_LAST) begin
      cnt_next = '0;
      idx_next = (idx_reg == IDX_LAST) ? '0 : idx_reg + IDX_W'(1);
    end
    state_next = (int'(cnt_next) < BLANK_CYC) ? ST_BLANK : ST_DRIVE;
  end

  // Pin values for the current slot; registered below so they lag the scan by one clock.
  always_comb begin
    seg_next = SEG_BLANK;
    dig_next = '1;
    if (state_reg == ST_DRIVE) begin
      dig_next = ~(NUM_DIGITS'(1) << idx_reg);
      if (active_valid_reg && dec_valid && !lzb_mask[idx_reg]) begin
        seg_next = dec_seg;
      end
      seg_next = seg_with_dp(seg_next, active_dp_reg[idx_reg]);
    end
  end

  // Load handshake: capture into shadow, commit to active at frame end.
  // A LOAD landing on the commit cycle skips the shadow entirely.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      shadow_data_reg  <= '0;
      shadow_dp_reg    <= '0;
      shadow_lzb_reg   <= 1'b0;
      pending_reg      <= 1'b0;
      active_data_reg  <= '0;
      active_dp_reg    <= '0;
      active_lzb_reg   <= 1'b0;
      active_valid_reg <= 1'b0;
    end else if (LOAD && frame_end) begin
      active_data_reg  <= DATA_IN;
      active_dp_reg    <= DP_IN;
      active_lzb_reg   <= LZB_EN;
      active_valid_reg <= 1'b1;
      pending_reg      <= 1'b0;
    end else if (LOAD) begin
      shadow_data_reg  <= DATA_IN;
      shadow_dp_reg    <= DP_IN;
      shadow_lzb_reg   <= LZB_EN;
      pending_reg      <= 1'b1;
    end else if (frame_end && pending_reg) begin
      active_data_reg  <= shadow_data_reg;
      active_dp_reg    <= shadow_dp_reg;
      active_lzb_reg   <= shadow_lzb_reg;
      active_valid_reg <= 1'b1;
      pending_reg      <= 1'b0;
    end
  end

  // Output pins, acknowledge and frame pulse registers.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      seg_reg  <= SEG_BLANK;
      dig_reg  <= '1;
      ack_reg  <= 1'b0;
      tick_reg <= 1'b0;
    end else begin
      seg_reg  <= seg_next;
      dig_reg  <= dig_next;
      ack_reg  <= frame_end && (pending_reg || LOAD);
      tick_reg <= frame_end;
    end
  end

  assign SEG_OUT    = seg_reg;
  assign DIG_SEL    = dig_reg;
  assign ACK        = ack_reg;
  assign FRAME_TICK = tick_reg;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Directed testbench for seg7_scan_ctrl with NUM_DIGITS=4, DIV=8, BLANK_CYC=2.
module tb_seg7_scan_ctrl;

  localparam int ND    = 4;
  localparam int DV    = 8;
  localparam int BC    = 2;
  localparam int FRAME = ND * DV;

  logic          CLK;
  logic          RST_N;
  logic          LOAD;
  logic [4*ND-1:0] DATA_IN;
  logic [ND-1:0] DP_IN;
  logic          LZB_EN;
  logic          ACK;
  logic [7:0]    SEG_OUT;
  logic [ND-1:0] DIG_SEL;
  logic          FRAME_TICK;

  int checks = 0;
  int errors = 0;

  logic [7:0]    seg_cap  [FRAME];
  logic [ND-1:0] dig_cap  [FRAME];
  logic          tick_cap [FRAME];
  int            cap_acks;

  seg7_scan_ctrl #(.NUM_DIGITS(ND), .DIV(DV), .BLANK_CYC(BC)) dut (
    .CLK        (CLK),
    .RST_N      (RST_N),
    .LOAD       (LOAD),
    .DATA_IN    (DATA_IN),
    .DP_IN      (DP_IN),
    .LZB_EN     (LZB_EN),
    .ACK        (ACK),
    .SEG_OUT    (SEG_OUT),
    .DIG_SEL    (DIG_SEL),
    .FRAME_TICK (FRAME_TICK)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  // Expected digit enables for slot j of a frame (j counts output cycles).
  function automatic logic [ND-1:0] exp_dig(input int j);
    logic [ND-1:0] one;
    one = 4'b0001;
    if ((j % DV) < BC) return 4'hF;
    return ~(one << (j / DV));
  endfunction

  // Expected segments for slot j given the per-digit patterns.
  function automatic logic [7:0] exp_seg(input int j, input logic [7:0] e3, input logic [7:0] e2,
                                         input logic [7:0] e1, input logic [7:0] e0);
    if ((j % DV) < BC) return 8'hFF;
    case (j / DV)
      0: return e0;
      1: return e1;
      2: return e2;
      default: return e3;
    endcase
  endfunction

  // Step negedges until FRAME_TICK is seen, counting ACK pulses on the way.
  task automatic wait_tick(output int acks, output bit timeout);
    acks    = 0;
    timeout = 1'b1;
    for (int k = 0; k < 3 * FRAME; k++) begin
      if (ACK === 1'b1) acks++;
      if (FRAME_TICK === 1'b1) begin
        timeout = 1'b0;
        break;
      end
      @(negedge CLK);
    end
  endtask

  // Record one full frame of pin values, one sample per clock.
  task automatic capture_frame();
    cap_acks = 0;
    for (int j = 0; j < FRAME; j++) begin
      @(negedge CLK);
      seg_cap[j]  = SEG_OUT;
      dig_cap[j]  = DIG_SEL;
      tick_cap[j] = FRAME_TICK;
      if (ACK === 1'b1) cap_acks++;
    end
  endtask

  task automatic drive_load(input logic [15:0] d, input logic [3:0] dp, input logic lzb);
    @(negedge CLK);
    DATA_IN = d;
    DP_IN   = dp;
    LZB_EN  = lzb;
    LOAD    = 1'b1;
    @(negedge CLK);
    LOAD    = 1'b0;
    DATA_IN = 16'hEEEE;
    DP_IN   = 4'hF;
    LZB_EN  = 1'b1;
  endtask

  task automatic test_reset(input string name, input bit wait_lit);
    if (wait_lit) begin
      for (int k = 0; k < 2 * FRAME && DIG_SEL === 4'hF; k++) @(negedge CLK);
    end
    @(posedge CLK);
    #3;
    RST_N = 1'b0;
    #1;
    checks++;
    if (SEG_OUT !== 8'hFF || DIG_SEL !== 4'hF || ACK !== 1'b0 || FRAME_TICK !== 1'b0) begin
      errors++;
      $display("FAIL %s_async: seg=%h dig=%h ack=%b tick=%b required seg=ff dig=f ack=0 tick=0",
               name, SEG_OUT, DIG_SEL, ACK, FRAME_TICK);
    end
    @(negedge CLK);
    @(negedge CLK);
    RST_N = 1'b1;
    for (int e = 1; e <= FRAME; e++) begin
      @(negedge CLK);
      checks++;
      if (DIG_SEL !== exp_dig(e - 1) || SEG_OUT !== 8'hFF || ACK !== 1'b0 ||
          FRAME_TICK !== logic'(e == FRAME)) begin
        errors++;
        $display("FAIL %s_clk%0d: seg=%h dig=%h ack=%b tick=%b required seg=ff dig=%h ack=0 tick=%b",
                 name, e, SEG_OUT, DIG_SEL, ACK, FRAME_TICK, exp_dig(e - 1), e == FRAME);
      end
    end
    $display("test_reset %s done", name);
  endtask

  task automatic test_load_basic();
    int acks;
    bit to;
    drive_load(16'h1234, 4'b0000, 1'b0);
    wait_tick(acks, to);
    checks++;
    if (to || acks != 1) begin
      errors++;
      $display("FAIL load_ack: acks=%0d timeout=%b required acks=1 timeout=0", acks, to);
    end
    capture_frame();
    for (int j = 0; j < FRAME; j++) begin
      checks++;
      if (seg_cap[j] !== exp_seg(j, 8'h9F, 8'h25, 8'h0D, 8'h99) || dig_cap[j] !== exp_dig(j) ||
          tick_cap[j] !== logic'(j == FRAME - 1)) begin
        errors++;
        $display("FAIL load_slot%0d: seg=%h dig=%h tick=%b required seg=%h dig=%h tick=%b", j,
                 seg_cap[j], dig_cap[j], tick_cap[j], exp_seg(j, 8'h9F, 8'h25, 8'h0D, 8'h99),
                 exp_dig(j), j == FRAME - 1);
      end
    end
    checks++;
    if (cap_acks != 0) begin
      errors++;
      $display("FAIL load_extra_ack: acks=%0d required 0", cap_acks);
    end
    $display("test_load_basic 1234 done");
  endtask

  task automatic test_lzb();
    int acks;
    bit to;
    logic [15:0] data [2];
    logic [7:0]  e1 [2];
    data[0] = 16'h0070; e1[0] = 8'h1B;
    data[1] = 16'h0000; e1[1] = 8'hFF;
    for (int c = 0; c < 2; c++) begin
      drive_load(data[c], 4'b0000, 1'b1);
      wait_tick(acks, to);
      checks++;
      if (to || acks != 1) begin
        errors++;
        $display("FAIL lzb%0d_ack: acks=%0d timeout=%b required acks=1 timeout=0", c, acks, to);
      end
      capture_frame();
      for (int j = 0; j < FRAME; j++) begin
        checks++;
        if (seg_cap[j] !== exp_seg(j, 8'hFF, 8'hFF, e1[c], 8'h03) || dig_cap[j] !== exp_dig(j)) begin
          errors++;
          $display("FAIL lzb%0d_slot%0d: seg=%h dig=%h required seg=%h dig=%h", c, j, seg_cap[j],
                   dig_cap[j], exp_seg(j, 8'hFF, 8'hFF, e1[c], 8'h03), exp_dig(j));
        end
      end
      $display("test_lzb data=%h done", data[c]);
    end
  endtask

  task automatic test_blank_dp();
    int acks;
    bit to;
    drive_load(16'h00A5, 4'b0010, 1'b0);
    wait_tick(acks, to);
    checks++;
    if (to || acks != 1) begin
      errors++;
      $display("FAIL blankdp_ack: acks=%0d timeout=%b required acks=1 timeout=0", acks, to);
    end
    capture_frame();
    for (int j = 0; j < FRAME; j++) begin
      checks++;
      if (seg_cap[j] !== exp_seg(j, 8'h03, 8'h03, 8'hFE, 8'h49) || dig_cap[j] !== exp_dig(j)) begin
        errors++;
        $display("FAIL blankdp_slot%0d: seg=%h dig=%h required seg=%h dig=%h", j, seg_cap[j],
                 dig_cap[j], exp_seg(j, 8'h03, 8'h03, 8'hFE, 8'h49), exp_dig(j));
      end
    end
    $display("test_blank_dp 00A5 done");
  endtask

  task automatic test_last_wins();
    int acks;
    bit to;
    drive_load(16'h1111, 4'b0000, 1'b0);
    drive_load(16'h2222, 4'b0000, 1'b0);
    wait_tick(acks, to);
    checks++;
    if (to || acks != 1) begin
      errors++;
      $display("FAIL lastwins_ack: acks=%0d timeout=%b required acks=1 timeout=0", acks, to);
    end
    capture_frame();
    for (int j = 0; j < FRAME; j++) begin
      checks++;
      if (seg_cap[j] !== exp_seg(j, 8'h25, 8'h25, 8'h25, 8'h25)) begin
        errors++;
        $display("FAIL lastwins_slot%0d: seg=%h required %h", j, seg_cap[j],
                 exp_seg(j, 8'h25, 8'h25, 8'h25, 8'h25));
      end
    end
    checks++;
    if (cap_acks != 0) begin
      errors++;
      $display("FAIL lastwins_extra_ack: acks=%0d required 0", cap_acks);
    end
    $display("test_last_wins 2222 done");
  endtask

  task automatic test_commit_cycle();
    int acks;
    bit to;
    @(negedge CLK);
    wait_tick(acks, to);
    checks++;
    if (to) begin
      errors++;
      $display("FAIL commit_sync: timeout=1 required 0");
    end
    // Position the LOAD so it is high on the next frame-end edge.
    for (int k = 0; k < FRAME - 1; k++) @(negedge CLK);
    DATA_IN = 16'h5678;
    DP_IN   = 4'b0000;
    LZB_EN  = 1'b0;
    LOAD    = 1'b1;
    @(negedge CLK);
    LOAD    = 1'b0;
    DATA_IN = 16'hEEEE;
    checks++;
    if (ACK !== 1'b1 || FRAME_TICK !== 1'b1) begin
      errors++;
      $display("FAIL commit_ack: ack=%b tick=%b required ack=1 tick=1", ACK, FRAME_TICK);
    end
    capture_frame();
    for (int j = 0; j < FRAME; j++) begin
      checks++;
      if (seg_cap[j] !== exp_seg(j, 8'h49, 8'h41, 8'h1B, 8'h01) || dig_cap[j] !== exp_dig(j)) begin
        errors++;
        $display("FAIL commit_slot%0d: seg=%h dig=%h required seg=%h dig=%h", j, seg_cap[j],
                 dig_cap[j], exp_seg(j, 8'h49, 8'h41, 8'h1B, 8'h01), exp_dig(j));
      end
    end
    checks++;
    if (cap_acks != 0) begin
      errors++;
      $display("FAIL commit_extra_ack: acks=%0d required 0", cap_acks);
    end
    $display("test_commit_cycle 5678 done");
  endtask

  task automatic test_frame_tick();
    int acks;
    bit to;
    int n;
    @(negedge CLK);
    wait_tick(acks, to);
    checks++;
    if (to) begin
      errors++;
      $display("FAIL tick_sync: timeout=1 required 0");
    end
    for (int f = 0; f < 3; f++) begin
      n = 0;
      for (int k = 0; k < 2 * FRAME; k++) begin
        @(negedge CLK);
        n++;
        checks++;
        if ($countones(~DIG_SEL) > 1 || (((n - 1) % DV) < BC && DIG_SEL !== 4'hF)) begin
          errors++;
          $display("FAIL tick_dig f%0d c%0d: dig=%h required one-hot-low, all ones when dark",
                   f, n, DIG_SEL);
        end
        if (FRAME_TICK === 1'b1) break;
      end
      checks++;
      if (n != FRAME) begin
        errors++;
        $display("FAIL tick_period f%0d: period=%0d required %0d", f, n, FRAME);
      end
      $display("test_frame_tick frame %0d period=%0d", f, n);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    RST_N   = 1'b1;
    LOAD    = 1'b0;
    DATA_IN = '0;
    DP_IN   = '0;
    LZB_EN  = 1'b0;
    test_reset("power_on", 1'b0);
    test_load_basic();
    test_lzb();
    test_blank_dp();
    test_last_wins();
    test_commit_cycle();
    test_frame_tick();
    test_reset("mid_frame", 1'b1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
